seg7_scan_2digit: RTL and testbench
===================================

# seg7_scan_2digit

Two-digit multiplexed 7-segment driver placed directly downstream of the 0–99 down-counter. It takes the counter's 7-bit binary value and converts it to two BCD digits with a sequential double-dabble engine. It then time-multiplexes the tens and ones digits onto one shared segment bus with per-digit enables. Values above 99 are shown as "--".

## Interface
Parameters:
- ticksPerDigit, 4: clkIn cycles each digit stays enabled per scan slot; must be ≥1.
- blankLeadingZero, 1: when 1, the tens digit is blanked while tens==0.
- activeLowSeg, 0: when 1, seg and an are both inverted at the output.

Ports:
- clkIn  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  7  binary count from the upstream counter, 0–127.
- seg  output  7  segment drive {g,f,e,d,c,b,a}; seg[0]=a; active-high unless activeLowSeg.
- an  output  2  digit enables; an[0]=ones, an[1]=tens; one-hot active-high unless activeLowSeg.
- busy  output  1  high while a conversion is in progress.

## Operation
- Registers:
  - lastVal[6:0]: value of the last conversion.
  - shift register: 7-bit binary plus 8-bit BCD.
  - iteration counter: 3 bits.
  - display registers: tensR[3:0], onesR[3:0], dashR.
  - scan divider.
  - digit select: sel, 0=ones, 1=tens.
- FSM states are IDLE, SHIFT and DONE.
  - IDLE: if value != lastVal, load value into the binary field and lastVal. Clear the BCD field and iteration counter. Go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: per cycle, first add 3 to each BCD nibble that is ≥5, then shift {bcd,bin} left 1. Go to DONE after 7 iterations.
  - DONE: copy the BCD field into tensR/onesR. Set dashR=(lastVal>99). Go to IDLE.
- value is ignored outside IDLE. A change during SHIFT/DONE is picked up on return to IDLE, because lastVal still differs.
- busy is 1 in SHIFT and DONE, 0 in IDLE.
- Scan divider:
  - counts 0..ticksPerDigit-1.
  - at wrap it returns to 0 and toggles sel.
- seg/an are registered:
  - an = sel ? 2'b10 : 2'b01.
  - seg shows the digit code for the selected digit.
- Digit codes, active-high gfedcba:
  - 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66
  - 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F
  - dash=7'h40, blank=7'h00.
- Digit selection rules:
  - dashR=1: both digits show dash; the blanking rule does not apply.
  - Tens digit with tensR==0 and blankLeadingZero=1: seg=blank; an still asserts for the tens digit.
- activeLowSeg=1 inverts seg and an after all of the above.
- Reset:
  - state=IDLE, busy=0, lastVal=0, tensR=onesR=0, dashR=0.
  - divider=0, sel=0.
  - an=2'b01, seg=7'h3F (both before polarity inversion).
  - A reset during SHIFT/DONE aborts the conversion; the display shows "0" on the next cycle.

## Timing
- Conversion latency:
  - Edge E0 samples a changed value (IDLE→SHIFT).
  - Edges E1..E7 perform the shifts.
  - Edge E8 executes DONE: display registers update and busy falls.
  - busy is high for exactly 8 cycles.
- seg reflects new display registers on the first scan edge after E8, i.e. E9 at the latest for the currently selected digit.
- Each digit is enabled for exactly ticksPerDigit cycles; full refresh is 2·ticksPerDigit cycles.
- seg and an change on the same edge, so there is never an enabled digit paired with the other digit's pattern.
- Back-to-back value changes: the minimum spacing between conversions is 9 cycles (8 busy + 1 IDLE sample).

## Test plan
- Reset:
  - Stimulus: rst=1 for 2 cycles with value=0, then release.
  - Required: an=01, seg=7'h3F, busy=0. an alternates 01/10 every 4 cycles. Tens slot seg=7'h00.
- Convert 99:
  - Stimulus: value=99 after reset.
  - Required: busy high for 8 cycles. Then ones slot seg=7'h6F and tens slot seg=7'h6F.
- Leading-zero blanking:
  - Stimulus: value=7, first with blankLeadingZero=1, then with 0.
  - Required: ones seg=7'h07. Tens seg=7'h00 with blanking; tens seg=7'h3F without.
- Out of range:
  - Stimulus: value=100, then value=127.
  - Required: both slots seg=7'h40 after conversion.
- Change while busy:
  - Stimulus: value 99→42, then 42→41 three cycles later.
  - Required: display shows 42. A second busy pulse starts the cycle after the first ends. Final display shows 41 (tens 7'h66, ones 7'h06).
- Mid-conversion reset and polarity:
  - Stimulus: assert rst during the 4th SHIFT cycle.
  - Required: next cycle busy=0 and seg=7'h3F. With activeLowSeg=1, the reset outputs are an=2'b10 and seg=7'h40.

Source files
------------

// File: rtl/seg7_scan_2digit.sv
// Two-digit multiplexed 7-segment driver: sequential double-dabble conversion of a
// 0..127 binary value, then tens/ones time-multiplexed onto one segment bus ("--" above 99).
module seg7_scan_2digit #(
  parameter int unsigned ticksPerDigit    = 4,
  parameter bit          blankLeadingZero = 1'b1,
  parameter bit          activeLowSeg     = 1'b0
) (
  input  logic       clkIn,
  input  logic       rst,
  input  logic [6:0] value,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       busy
);

  localparam int unsigned DivW = (ticksPerDigit > 1) ? $clog2(ticksPerDigit) : 1;
  localparam logic [6:0]  SegMask = {7{activeLowSeg}};
  localparam logic [1:0]  AnMask  = {2{activeLowSeg}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_n;
  logic [6:0]      last_val;
  logic [14:0]     sh;          // {tens, ones, bin}
  logic [2:0]      iter;
  logic [3:0]      tens_r, ones_r;
  logic            dash_r;
  logic [DivW-1:0] div, div_n;
  logic            sel, sel_n;
  logic [7:0]      bcd_adj;
  logic [6:0]      seg_raw;

  function automatic logic [6:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0:    digit_code = 7'h3F;
      4'd1:    digit_code = 7'h06;
      4'd2:    digit_code = 7'h5B;
      4'd3:    digit_code = 7'h4F;
      4'd4:    digit_code = 7'h66;
      4'd5:    digit_code = 7'h6D;
      4'd6:    digit_code = 7'h7D;
      4'd7:    digit_code = 7'h07;
      4'd8:    digit_code = 7'h7F;
      4'd9:    digit_code = 7'h6F;
      default: digit_code = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clkIn) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (value != last_val) state_n = SHIFT;
      SHIFT:   if (iter == 3'd6) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_comb begin
    bcd_adj[3:0] = (sh[10:7]  >= 4'd5) ? sh[10:7]  + 4'd3 : sh[10:7];
    bcd_adj[7:4] = (sh[14:11] >= 4'd5) ? sh[14:11] + 4'd3 : sh[14:11];
  end

  always_ff @(posedge clkIn) begin
    if (rst) begin
      last_val <= '0;
      sh       <= '0;
      iter     <= '0;
      tens_r   <= '0;
      ones_r   <= '0;
      dash_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (value != last_val) begin
          last_val <= value;
          sh       <= {8'h00, value};
          iter     <= '0;
        end
        SHIFT: begin
          sh   <= {bcd_adj, sh[6:0]} << 1;
          iter <= iter + 3'd1;
        end
        DONE: begin
          tens_r <= sh[14:11];
          ones_r <= sh[10:7];
          dash_r <= (last_val > 7'd99);
        end
        default: ;
      endcase
    end
  end

  // seg/an are registered from the next-cycle select so both switch on the same edge
  always_comb begin
    if (div == DivW'(ticksPerDigit - 1)) begin
      div_n = '0;
      sel_n = ~sel;
    end else begin
      div_n = div + 1'b1;
      sel_n = sel;
    end
    if (dash_r)                                          seg_raw = 7'h40;
    else if (sel_n && blankLeadingZero && tens_r == 4'd0) seg_raw = 7'h00;
    else if (sel_n)                                      seg_raw = digit_code(tens_r);
    else                                                 seg_raw = digit_code(ones_r);
  end

  always_ff @(posedge clkIn) begin
    if (rst) begin
      div <= '0;
      sel <= 1'b0;
      seg <= 7'h3F ^ SegMask;
      an  <= 2'b01 ^ AnMask;
    end else begin
      div <= div_n;
      sel <= sel_n;
      seg <= seg_raw ^ SegMask;
      an  <= (sel_n ? 2'b10 : 2'b01) ^ AnMask;
    end
  end

endmodule

// File: tb/tb_seg7_scan_2digit.sv
// Randomized self-checking bench for seg7_scan_2digit: three parameterisations share
// one stimulus stream and are compared each cycle against a decimal/countdown reference.
module tb_seg7_scan_2digit;

  logic       clkIn = 1'b0;
  logic       rst   = 1'b1;
  logic [6:0] value = '0;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] an_a, an_b, an_c;
  logic       busy_a, busy_b, busy_c;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: last accepted value, cycles left in conversion, shown value, edges since reset
  int m_last = 0;
  int m_cnt  = 0;
  int m_disp = 0;
  int m_k    = 0;
  int m_shown = 0;

  localparam logic [6:0] CODES [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clkIn = ~clkIn;

  seg7_scan_2digit dut_a (
    .clkIn(clkIn), .rst(rst), .value(value), .seg(seg_a), .an(an_a), .busy(busy_a)
  );

  seg7_scan_2digit #(.ticksPerDigit(3), .blankLeadingZero(1'b0)) dut_b (
    .clkIn(clkIn), .rst(rst), .value(value), .seg(seg_b), .an(an_b), .busy(busy_b)
  );

  seg7_scan_2digit #(.ticksPerDigit(2), .activeLowSeg(1'b1)) dut_c (
    .clkIn(clkIn), .rst(rst), .value(value), .seg(seg_c), .an(an_c), .busy(busy_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int v, input bit sel, input bit blank, input bit al);
    logic [6:0] s;
    if (v > 99)                       s = 7'h40;
    else if (sel && blank && v < 10)  s = 7'h00;
    else if (sel)                     s = CODES[v / 10];
    else                              s = CODES[v % 10];
    return al ? ~s : s;
  endfunction

  function automatic logic [1:0] ref_an(input bit sel, input bit al);
    logic [1:0] a;
    a = sel ? 2'b10 : 2'b01;
    return al ? ~a : a;
  endfunction

  task automatic check_inst(input string nm, input logic [6:0] s, input logic [1:0] a,
                            input logic b, input int t, input bit blank, input bit al);
    bit sel;
    sel = ((m_k / t) % 2) == 1;
    check({nm, ".seg"},  32'(s), 32'(ref_seg(m_shown, sel, blank, al)));
    check({nm, ".an"},   32'(a), 32'(ref_an(sel, al)));
    check({nm, ".busy"}, 32'(b), 32'(m_cnt > 0));
  endtask

  // one clock: advance the reference with the inputs sampled at this edge, then compare
  task automatic step();
    @(posedge clkIn);
    m_shown = m_disp;   // segment pattern latched this edge uses the pre-edge display
    if (rst) begin
      m_last = 0; m_cnt = 0; m_disp = 0; m_k = 0; m_shown = 0;
    end else begin
      m_k++;
      if (m_cnt == 0) begin
        if (int'(value) != m_last) begin
          m_last = int'(value);
          m_cnt  = 8;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) m_disp = m_last;
      end
    end
    @(negedge clkIn);
    check_inst("a", seg_a, an_a, busy_a, 4, 1'b1, 1'b0);
    check_inst("b", seg_b, an_b, busy_b, 3, 1'b0, 1'b0);
    check_inst("c", seg_c, an_c, busy_c, 2, 1'b1, 1'b1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // reset with value 0, then free-run showing "0"
    rst = 1'b1; value = 7'd0;
    run(2);
    rst = 1'b0;
    run(12);
    // directed values: full range, leading zero, out of range
    value = 7'd99;  run(20);
    value = 7'd7;   run(20);
    value = 7'd100; run(20);
    value = 7'd127; run(20);
    value = 7'd0;   run(20);
    // changes while busy
    value = 7'd99;  run(20);
    value = 7'd42;  run(3);
    value = 7'd41;  run(30);
    // reset during the 4th shift cycle
    value = 7'd55;  run(4);
    rst = 1'b1;     run(1);
    rst = 1'b0;     run(15);
    // randomized value changes and occasional resets
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 10)       value = 7'($urandom_range(0, 127));
      else if (r < 14)  value = 7'($urandom_range(95, 104));
      rst = (r == 99);
      step();
    end
    rst = 1'b0;
    run(20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
